// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and helpers for the exhaustive gate sweep checker.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int sweep_len(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/result bundle between the sweep checker and the gate under test.
interface gate_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            fail_valid;

    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, err_count, first_fail_vec, fail_valid
    );

    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, err_count, first_fail_vec, fail_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Walks every input vector of a small combinational gate, holds each for SETTLE
// cycles, then compares the gate output against the EXP_TT truth table.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int                          N_IN   = 2,
    parameter int                          SETTLE = 1,
    parameter logic [sweep_len(N_IN)-1:0]  EXP_TT = 4'b0111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_sweep_checker_if.master bus
);

    localparam int              LEN        = sweep_len(N_IN);
    localparam int              SW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(LEN - 1);
    localparam logic [SW-1:0]   SETTLE_END = SW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_bad_settle
        $error("gate_sweep_checker: SETTLE must be >= 1");
    end

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            fv_q, fv_d;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        fv_d     = fv_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    ffv_d    = '0;
                    fv_d     = 1'b0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_END) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (bus.dut_out != EXP_TT[vec_q]) begin
                    err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffv_d = vec_q;
                    end
                end
                // The last vector's own comparison must already be in err_d here.
                if (vec_q == LAST_VEC) begin
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + 1'b1;
                    settle_d = '0;
                    state_d  = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        stim_d = busy_d ? vec_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            stim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= '0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            fv_q     <= fv_d;
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;
    assign bus.fail_valid     = fv_q;

endmodule
